// File: rtl/noise_amp_sequencer.sv
// Purpose : sequences the 5-bit noise amplitude through OFF / FIXED / triangle RAMP / on-off BURST,
//           paced by sample_tick; config changes during a ramp/burst are held until the cycle boundary.
// Latency : 1 clk from config handshake to amp_out; steps land on the edge sampling the period-th tick.
// Backpressure: cfg_ready=1 when idle/holding; while busy, one config may be buffered (cfg_ready=!pend_valid).
//
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   sample_tick        - one-cycle sample-rate enable; the only thing the step counter counts
//   cfg_valid/cfg_ready- config handshake; cfg_mode (00 OFF, 01 FIXED, 10 RAMP, 11 BURST),
//                        cfg_amp (target amplitude), cfg_period (ticks per step, 0 behaves as 1)
//   amp_out            - registered amplitude to the noise generator
//   noise_active       - registered (amp_out != 0)
//   busy               - ramp or burst in progress
//   cycle_done         - one-clk pulse coincident with the first amplitude of a new ramp/burst cycle
module noise_amp_sequencer #(
    parameter int AMP_WIDTH    = 5,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_mode,
    input  logic [AMP_WIDTH-1:0]    cfg_amp,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    output logic [AMP_WIDTH-1:0]    amp_out,
    output logic                    noise_active,
    output logic                    busy,
    output logic                    cycle_done
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HOLD      = 3'd1;
    localparam logic [2:0] ST_RAMP_UP   = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_BURST_ON  = 3'd4;
    localparam logic [2:0] ST_BURST_OFF = 3'd5;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_FIXED = 2'b01;
    localparam logic [1:0] MODE_RAMP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    // Active configuration and running state
    logic [2:0]              state_q,      state_d;
    logic [AMP_WIDTH-1:0]    amp_q,        amp_d;
    logic                    active_q,     active_d;
    logic                    cycle_done_q, cycle_done_d;
    logic [1:0]              mode_q,       mode_d;
    logic [AMP_WIDTH-1:0]    target_q,     target_d;
    logic [PERIOD_WIDTH-1:0] period_q,     period_d;
    logic [PERIOD_WIDTH-1:0] tick_cnt_q,   tick_cnt_d;

    // One-deep pending slot for configs accepted while busy
    logic                    pend_valid_q,  pend_valid_d;
    logic [1:0]              pend_mode_q,   pend_mode_d;
    logic [AMP_WIDTH-1:0]    pend_amp_q,    pend_amp_d;
    logic [PERIOD_WIDTH-1:0] pend_period_q, pend_period_d;

    logic [PERIOD_WIDTH-1:0] eff_period;
    logic [PERIOD_WIDTH-1:0] last_cnt;
    logic [AMP_WIDTH-1:0]    amp_inc;
    logic [AMP_WIDTH-1:0]    amp_dec;
    logic                    busy_w;
    logic                    accept;
    logic                    step;
    logic                    boundary;
    logic                    apply;
    logic [1:0]              app_mode;
    logic [AMP_WIDTH-1:0]    app_amp;
    logic [PERIOD_WIDTH-1:0] app_period;

    assign busy_w     = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    assign cfg_ready  = busy_w ? !pend_valid_q : 1'b1;
    assign accept     = cfg_valid && cfg_ready;
    assign eff_period = (period_q == '0) ? PERIOD_WIDTH'(1) : period_q;
    assign last_cnt   = eff_period - PERIOD_WIDTH'(1);
    assign step       = busy_w && sample_tick && (tick_cnt_q == last_cnt);
    assign amp_inc    = amp_q + AMP_WIDTH'(1);
    assign amp_dec    = amp_q - AMP_WIDTH'(1);

    always_comb begin
        state_d       = state_q;
        amp_d         = amp_q;
        mode_d        = mode_q;
        target_d      = target_q;
        period_d      = period_q;
        tick_cnt_d    = tick_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_mode_d   = pend_mode_q;
        pend_amp_d    = pend_amp_q;
        pend_period_d = pend_period_q;
        cycle_done_d  = 1'b0;
        boundary      = 1'b0;
        apply         = 1'b0;
        app_mode      = cfg_mode;
        app_amp       = cfg_amp;
        app_period    = cfg_period;

        // Ticks only count while a ramp/burst is running
        if (busy_w && sample_tick) begin
            tick_cnt_d = step ? '0 : tick_cnt_q + PERIOD_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                apply = accept;
            end
            ST_RAMP_UP: begin
                if (step) begin
                    // amp==target here only when target is 0: every step is then a boundary
                    if (amp_q == target_q) begin
                        boundary = 1'b1;
                    end else begin
                        amp_d = amp_inc;
                        // Turn around on reaching the peak so no step is spent sitting there
                        if (amp_inc == target_q) begin
                            state_d = ST_RAMP_DOWN;
                        end
                    end
                end
            end
            ST_RAMP_DOWN: begin
                if (step) begin
                    amp_d = amp_dec;
                    if (amp_dec == '0) begin
                        boundary = 1'b1;
                    end
                end
            end
            ST_BURST_ON: begin
                if (step) begin
                    state_d = ST_BURST_OFF;
                    amp_d   = '0;
                end
            end
            ST_BURST_OFF: begin
                if (step) begin
                    boundary = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                amp_d   = '0;
            end
        endcase

        if (boundary) begin
            cycle_done_d = 1'b1;
            // Default continuation: start the next cycle of the active mode
            if (mode_q == MODE_BURST) begin
                state_d = ST_BURST_ON;
                amp_d   = target_q;
            end else begin
                state_d = ST_RAMP_UP;
                amp_d   = '0;
            end
            if (pend_valid_q) begin
                apply        = 1'b1;
                app_mode     = pend_mode_q;
                app_amp      = pend_amp_q;
                app_period   = pend_period_q;
                pend_valid_d = 1'b0;
            end else if (accept) begin
                // Offer landing exactly on the boundary bypasses the pending slot
                apply = 1'b1;
            end
        end else if (busy_w && accept) begin
            pend_valid_d  = 1'b1;
            pend_mode_d   = cfg_mode;
            pend_amp_d    = cfg_amp;
            pend_period_d = cfg_period;
        end

        if (apply) begin
            mode_d     = app_mode;
            target_d   = app_amp;
            period_d   = app_period;
            tick_cnt_d = '0;
            case (app_mode)
                MODE_OFF: begin
                    state_d = ST_IDLE;
                    amp_d   = '0;
                end
                MODE_FIXED: begin
                    state_d = ST_HOLD;
                    amp_d   = app_amp;
                end
                MODE_RAMP: begin
                    state_d = ST_RAMP_UP;
                    amp_d   = '0;
                end
                default: begin
                    state_d = ST_BURST_ON;
                    amp_d   = app_amp;
                end
            endcase
        end

        active_d = (amp_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            amp_q         <= '0;
            active_q      <= 1'b0;
            cycle_done_q  <= 1'b0;
            mode_q        <= MODE_OFF;
            target_q      <= '0;
            period_q      <= '0;
            tick_cnt_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_mode_q   <= MODE_OFF;
            pend_amp_q    <= '0;
            pend_period_q <= '0;
        end else begin
            state_q       <= state_d;
            amp_q         <= amp_d;
            active_q      <= active_d;
            cycle_done_q  <= cycle_done_d;
            mode_q        <= mode_d;
            target_q      <= target_d;
            period_q      <= period_d;
            tick_cnt_q    <= tick_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_mode_q   <= pend_mode_d;
            pend_amp_q    <= pend_amp_d;
            pend_period_q <= pend_period_d;
        end
    end

    assign amp_out      = amp_q;
    assign noise_active = active_q;
    assign busy         = busy_w;
    assign cycle_done   = cycle_done_q;

endmodule
